// File: rtl/sram_bank_pkg.sv
// Shared types and helpers for the SRAM bank port controller.
package sram_bank_pkg;

  localparam int WS_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT,
    RESP
  } state_t;

  // Byte address to word index; callers zero-extend narrower addresses.
  function automatic logic [31:0] word_idx(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

endpackage

// File: rtl/sram_bank_ctrl.sv
// Slave-port controller for one single-port SRAM macro: one command in flight,
// one macro strobe, optional wait states, one response beat per command.
module sram_bank_ctrl
  import sram_bank_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0,
  localparam int BE_W       = DATA_WIDTH / 8,
  localparam int MACRO_AW   = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [BE_W-1:0]       be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [BE_W-1:0]       sram_wmask_o,
  output logic [MACRO_AW-1:0]   sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_din_o,
  input  logic [DATA_WIDTH-1:0] sram_dout_i
);

  state_t                r_state;
  state_t                w_next;
  logic [WS_CNT_W-1:0]   r_cnt;
  logic                  r_we;
  logic                  r_oor;
  logic [BE_W-1:0]       r_be;
  logic [MACRO_AW-1:0]   r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [31:0]           w_idx;
  logic                  w_accept;
  logic                  w_toResp;

  assign w_idx    = word_idx(32'(addr_i));
  assign gnt_o    = req_i & ~rst & ((r_state == IDLE) | (r_state == RESP));
  assign w_accept = gnt_o;
  assign w_toResp = ((r_state == STROBE) && (WAIT_STATES == 0)) ||
                    ((r_state == WAIT) && (r_cnt == WS_CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = STROBE;
      STROBE:  w_next = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (r_cnt == WS_CNT_W'(1)) w_next = RESP;
      RESP:    w_next = w_accept ? STROBE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Command registers stay frozen from acceptance until the next accept so the
  // macro sees stable address/data for the whole STROBE..RESP window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_oor   <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= we_i;
        r_oor   <= (w_idx >= 32'(MEM_DEPTH));
        r_be    <= be_i;
        r_addr  <= MACRO_AW'(w_idx);
        r_wdata <= wdata_i;
      end
      if (r_state == STROBE)    r_cnt <= WS_CNT_W'(WAIT_STATES);
      else if (r_state == WAIT) r_cnt <= r_cnt - 1'b1;
      if (w_toResp) r_rdata <= (r_we | r_oor) ? '0 : sram_dout_i;
    end
  end

  assign sram_csb_o   = ~((r_state == STROBE) & ~r_oor);
  assign sram_web_o   = ~((r_state == STROBE) & ~r_oor & r_we);
  assign sram_wmask_o = r_be;
  assign sram_addr_o  = r_addr;
  assign sram_din_o   = r_wdata;

  assign rvalid_o = (r_state == RESP);
  assign rdata_o  = rvalid_o ? r_rdata : '0;
  assign err_o    = rvalid_o & r_oor;

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Bench for sram_bank_ctrl: two instances (no wait states / 3 wait states with a
// shallow macro) checked cycle by cycle against a transaction-level model.
module tb_sram_bank_ctrl;

  localparam int DW     = 32;
  localparam int AW     = 10;
  localparam int BEW    = 4;
  localparam int MAW    = 8;
  localparam int WS0    = 0;
  localparam int WS1    = 3;
  localparam int DEPTH0 = 256;
  localparam int DEPTH1 = 192;

  typedef struct packed {
    logic           we;
    logic [AW-1:0]  addr;
    logic [BEW-1:0] be;
    logic [DW-1:0]  wdata;
  } cmd_t;

  logic clk = 1'b0;
  logic rst;
  logic           req[2];
  logic           we[2];
  logic [AW-1:0]  addr[2];
  logic [BEW-1:0] be[2];
  logic [DW-1:0]  wdata[2];
  logic           gnt[2];
  logic           rvalid[2];
  logic           err[2];
  logic           csb[2];
  logic           web[2];
  logic [DW-1:0]  rdata[2];
  logic [DW-1:0]  din[2];
  logic [DW-1:0]  dout[2];
  logic [BEW-1:0] wmask[2];
  logic [MAW-1:0] sramAddr[2];

  logic [DW-1:0] macroMem[2][256];
  logic [DW-1:0] refMem[2][256];

  // Transaction-level model state: one outstanding command per instance.
  bit             pend[2];
  bit             pWe[2];
  bit             pOor[2];
  bit             sinceReset[2];
  int             strobeCyc[2];
  int             respCyc[2];
  int             pIdx[2];
  logic [BEW-1:0] pBe[2];
  logic [DW-1:0]  pWdata[2];
  logic [DW-1:0]  pRdata[2];
  int             cyc;
  cmd_t           q0[$];
  cmd_t           q1[$];
  bit             holdReq;
  bit             randRst;
  bit             rstForce;
  int             checks;
  int             errors;

  always #5 clk = ~clk;

  sram_bank_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH0), .WAIT_STATES(WS0)) u0 (
    .clk(clk), .rst(rst), .req_i(req[0]), .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]),
    .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
    .sram_csb_o(csb[0]), .sram_web_o(web[0]), .sram_wmask_o(wmask[0]), .sram_addr_o(sramAddr[0]),
    .sram_din_o(din[0]), .sram_dout_i(dout[0])
  );

  sram_bank_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH1), .WAIT_STATES(WS1)) u1 (
    .clk(clk), .rst(rst), .req_i(req[1]), .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]),
    .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
    .sram_csb_o(csb[1]), .sram_web_o(web[1]), .sram_wmask_o(wmask[1]), .sram_addr_o(sramAddr[1]),
    .sram_din_o(din[1]), .sram_dout_i(dout[1])
  );

  function automatic logic [DW-1:0] initWord(input int k, input int i);
    return 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101) ^ 32'(k << 20);
  endfunction

  // Macro model: asynchronous read of the held address, byte-masked write on the clock.
  assign dout[0] = macroMem[0][sramAddr[0]];
  assign dout[1] = macroMem[1][sramAddr[1]];

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) macroMem[k][i] = initWord(k, i);
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++)
        if (!csb[k] && !web[k])
          for (int b = 0; b < BEW; b++)
            if (wmask[k][b]) macroMem[k][sramAddr[k]][8*b +: 8] <= din[k][8*b +: 8];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, actual, expected);
    end
  endtask

  task automatic pushCmd(input logic w, input logic [AW-1:0] a, input logic [BEW-1:0] b, input logic [DW-1:0] d);
    cmd_t c;
    c.we = w; c.addr = a; c.be = b; c.wdata = d;
    q0.push_back(c);
    q1.push_back(c);
  endtask

  function automatic int qSize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic cmd_t headOf(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  // One clock cycle: drive inputs at the falling edge, check, then advance the model.
  task automatic applyStimulus();
    cmd_t c;
    int depth, ws, idx;
    bit expGnt, inResp, inStrobe, touch;
    @(negedge clk);
    rst = rstForce || (randRst && ($urandom_range(0, 249) == 0));
    for (int k = 0; k < 2; k++) begin
      if (qSize(k) > 0 && (holdReq || $urandom_range(0, 3) != 0)) begin
        c = headOf(k);
        req[k] = 1'b1; we[k] = c.we; addr[k] = c.addr; be[k] = c.be; wdata[k] = c.wdata;
      end else begin
        req[k] = 1'b0; we[k] = 1'($urandom); addr[k] = AW'($urandom);
        be[k] = BEW'($urandom); wdata[k] = $urandom;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      depth    = (k == 0) ? DEPTH0 : DEPTH1;
      ws       = (k == 0) ? WS0 : WS1;
      expGnt   = req[k] && !rst && (!pend[k] || respCyc[k] == cyc);
      inResp   = pend[k] && respCyc[k] == cyc;
      inStrobe = pend[k] && strobeCyc[k] == cyc;
      touch    = inStrobe && !pOor[k];
      checkOutput($sformatf("u%0d.gnt", k), 32'(gnt[k]), 32'(expGnt));
      checkOutput($sformatf("u%0d.rvalid", k), 32'(rvalid[k]), 32'(inResp));
      checkOutput($sformatf("u%0d.rdata", k), rdata[k], inResp ? pRdata[k] : 32'h0);
      checkOutput($sformatf("u%0d.err", k), 32'(err[k]), 32'(inResp && pOor[k]));
      checkOutput($sformatf("u%0d.csb", k), 32'(csb[k]), 32'(!touch));
      checkOutput($sformatf("u%0d.web", k), 32'(web[k]), 32'(!(touch && pWe[k])));
      if (pend[k] && !pOor[k]) begin
        checkOutput($sformatf("u%0d.addr", k), 32'(sramAddr[k]), 32'(pIdx[k]));
        checkOutput($sformatf("u%0d.wmask", k), 32'(wmask[k]), 32'(pBe[k]));
        checkOutput($sformatf("u%0d.din", k), din[k], pWdata[k]);
      end else if (sinceReset[k]) begin
        checkOutput($sformatf("u%0d.rstAddr", k), 32'(sramAddr[k]), 32'h0);
        checkOutput($sformatf("u%0d.rstWmask", k), 32'(wmask[k]), 32'h0);
        checkOutput($sformatf("u%0d.rstDin", k), din[k], 32'h0);
      end
      if (rst) begin
        pend[k] = 1'b0;
        sinceReset[k] = 1'b1;
      end else begin
        if (inResp && !expGnt) pend[k] = 1'b0;
        if (expGnt) begin
          idx          = int'(addr[k]) / 4;
          pend[k]      = 1'b1;
          pWe[k]       = we[k];
          pOor[k]      = idx >= depth;
          pIdx[k]      = idx;
          pBe[k]       = be[k];
          pWdata[k]    = wdata[k];
          strobeCyc[k] = cyc + 1;
          respCyc[k]   = cyc + 2 + ws;
          sinceReset[k] = 1'b0;
          pRdata[k]    = (!we[k] && !pOor[k]) ? refMem[k][idx] : 32'h0;
          if (we[k] && !pOor[k])
            for (int b = 0; b < BEW; b++)
              if (be[k][b]) refMem[k][idx][8*b +: 8] = wdata[k][8*b +: 8];
          if (k == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
        end
      end
    end
    cyc++;
  endtask

  task automatic runUntilIdle(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || pend[0] || pend[1]) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("drained", 32'(q0.size() + q1.size() + int'(pend[0]) + int'(pend[1])), 32'h0);
    applyStimulus();
  endtask

  initial begin
    int n;
    logic [7:0] word;
    checks = 0; errors = 0; cyc = 0;
    holdReq = 1'b1; randRst = 1'b0; rstForce = 1'b1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; be[k] = '0; wdata[k] = '0;
      pend[k] = 1'b0; sinceReset[k] = 1'b1;
      for (int i = 0; i < 256; i++) refMem[k][i] = initWord(k, i);
    end
    repeat (2) @(posedge clk);
    repeat (2) applyStimulus();
    rstForce = 1'b0;
    applyStimulus();

    $display("[TB] write, read-back, back-to-back reads");
    pushCmd(1'b1, 10'h010, 4'hF, 32'hDEADBEEF);
    runUntilIdle(50);
    pushCmd(1'b0, 10'h010, 4'h0, 32'h0);
    runUntilIdle(50);
    pushCmd(1'b0, 10'h004, 4'hF, 32'h0);
    pushCmd(1'b0, 10'h008, 4'hF, 32'h0);
    pushCmd(1'b0, 10'h00C, 4'hF, 32'h0);
    runUntilIdle(50);

    $display("[TB] range boundaries and empty byte mask");
    pushCmd(1'b0, 10'h3FC, 4'hF, 32'h0);
    pushCmd(1'b1, 10'h300, 4'hF, 32'h11223344);
    pushCmd(1'b0, 10'h300, 4'hF, 32'h0);
    pushCmd(1'b1, 10'h2FC, 4'h5, 32'hA5A5A5A5);
    pushCmd(1'b0, 10'h2FC, 4'h0, 32'h0);
    pushCmd(1'b1, 10'h010, 4'h0, 32'h0BADF00D);
    pushCmd(1'b0, 10'h010, 4'hF, 32'h0);
    runUntilIdle(100);

    $display("[TB] reset while waiting");
    pushCmd(1'b0, 10'h014, 4'hF, 32'h0);
    n = 0;
    while (!(pend[1] && cyc == strobeCyc[1] + 1) && n < 50) begin
      applyStimulus();
      n++;
    end
    checkOutput("reachWait", 32'(pend[1] && cyc == strobeCyc[1] + 1), 32'h1);
    rstForce = 1'b1;
    applyStimulus();
    rstForce = 1'b0;
    repeat (6) applyStimulus();
    pushCmd(1'b0, 10'h014, 4'hF, 32'h0);
    runUntilIdle(50);

    $display("[TB] randomized traffic");
    randRst = 1'b1;
    for (int t = 0; t < 300; t++) begin
      holdReq = 1'($urandom);
      for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
        word = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(176, 255));
        pushCmd(1'($urandom), {word, 2'($urandom)}, BEW'($urandom), $urandom);
      end
      runUntilIdle(300);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
